// File: rtl/alu_operand_stage.sv
// alu_operand_stage: pipeline register between decode/register read and the 16-bit ALU.
// Picks forwarded operands, extends the immediate and stalls on load-use hazards.
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [7:0]        imm,
    input  logic              use_imm,
    input  logic              imm_signed,
    input  logic [OP_W-1:0]   alu_op_in,
    input  logic              ex_wr_en,
    input  logic [REG_AW-1:0] ex_wr_addr,
    input  logic [DATA_W-1:0] ex_wr_data,
    input  logic              ex_is_load,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   alu_op,
    output logic [REG_AW-1:0] rd_out
);
    localparam int IMM_W = 8;

    function automatic logic [DATA_W-1:0] forwardSel(
        input logic [REG_AW-1:0] srcAddr,
        input logic [DATA_W-1:0] rfData,
        input logic              exEn,
        input logic [REG_AW-1:0] exAddr,
        input logic [DATA_W-1:0] exData,
        input logic              exLoad,
        input logic              wbEn,
        input logic [REG_AW-1:0] wbAddr,
        input logic [DATA_W-1:0] wbData
    );
        logic [DATA_W-1:0] sel;
        if (srcAddr == {REG_AW{1'b0}}) begin
            sel = {DATA_W{1'b0}};
        end else if (exEn && !exLoad && (exAddr == srcAddr)) begin
            sel = exData;
        end else if (wbEn && (wbAddr == srcAddr)) begin
            sel = wbData;
        end else begin
            sel = rfData;
        end
        return sel;
    endfunction

    function automatic logic [DATA_W-1:0] extendImm(
        input logic [IMM_W-1:0] immRaw,
        input logic             signExt
    );
        return {{(DATA_W-IMM_W){immRaw[IMM_W-1] & signExt}}, immRaw};
    endfunction

    logic [DATA_W-1:0] fwdRs_s;
    logic [DATA_W-1:0] fwdRt_s;
    logic [DATA_W-1:0] immExt_s;
    logic [DATA_W-1:0] opB_s;
    logic              exLoadPending_s;
    logic              hazard_s;
    logic              inReady_s;
    logic              transfer_s;

    logic              outValid_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [OP_W-1:0]   aluOp_r;
    logic [REG_AW-1:0] rd_r;

    // Operand selection, hazard detection and upstream ready.
    always_comb begin
        fwdRs_s  = forwardSel(rs_addr, rs_data, ex_wr_en, ex_wr_addr, ex_wr_data,
                              ex_is_load, wb_wr_en, wb_wr_addr, wb_wr_data);
        fwdRt_s  = forwardSel(rt_addr, rt_data, ex_wr_en, ex_wr_addr, ex_wr_data,
                              ex_is_load, wb_wr_en, wb_wr_addr, wb_wr_data);
        immExt_s = extendImm(imm, imm_signed);
        if (use_imm) begin
            opB_s = immExt_s;
        end else begin
            opB_s = fwdRt_s;
        end
        // rt is only a hazard source when it actually feeds operand B
        exLoadPending_s = ex_wr_en & ex_is_load & (ex_wr_addr != {REG_AW{1'b0}});
        hazard_s  = exLoadPending_s &
                    ((ex_wr_addr == rs_addr) | (!use_imm & (ex_wr_addr == rt_addr)));
        inReady_s = !flush & !hazard_s & (!outValid_r | out_ready);
        transfer_s = in_valid & inReady_s;
    end

    // Output bundle register: flush, load, consume or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid_r <= 1'b0;
            a_r        <= {DATA_W{1'b0}};
            b_r        <= {DATA_W{1'b0}};
            aluOp_r    <= {OP_W{1'b0}};
            rd_r       <= {REG_AW{1'b0}};
        end else if (flush) begin
            outValid_r <= 1'b0;
        end else if (transfer_s) begin
            outValid_r <= 1'b1;
            a_r        <= fwdRs_s;
            b_r        <= opB_s;
            aluOp_r    <= alu_op_in;
            rd_r       <= rd_addr;
        end else if (outValid_r && out_ready) begin
            outValid_r <= 1'b0;
        end else begin
            outValid_r <= outValid_r;
        end
    end

    assign in_ready  = inReady_s;
    assign out_valid = outValid_r;
    assign a         = a_r;
    assign b         = b_r;
    assign alu_op    = aluOp_r;
    assign rd_out    = rd_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a randomized
// run, all compared against a behavioural model of the operand stage.
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  rs_addr, rt_addr, rd_addr;
    logic [15:0] rs_data, rt_data;
    logic [7:0]  imm;
    logic        use_imm, imm_signed;
    logic [2:0]  alu_op_in;
    logic        ex_wr_en, ex_is_load;
    logic [2:0]  ex_wr_addr;
    logic [15:0] ex_wr_data;
    logic        wb_wr_en;
    logic [2:0]  wb_wr_addr;
    logic [15:0] wb_wr_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] a, b;
    logic [2:0]  alu_op, rd_out;

    int checks   = 0;
    int failures = 0;

    logic        mValid;
    logic [15:0] mA, mB;
    logic [2:0]  mOp, mRd;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .use_imm(use_imm),
        .imm_signed(imm_signed), .alu_op_in(alu_op_in),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .ex_is_load(ex_is_load), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .wb_wr_data(wb_wr_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .a(a), .b(b), .alu_op(alu_op), .rd_out(rd_out)
    );

    // Reference: value a source register reads as, given the in-flight writers.
    function automatic logic [15:0] refSrc(input logic [2:0] addr, input logic [15:0] rf);
        if (addr == 3'd0) return 16'h0000;
        if (ex_wr_en && !ex_is_load && ex_wr_addr == addr) return ex_wr_data;
        if (wb_wr_en && wb_wr_addr == addr) return wb_wr_data;
        return rf;
    endfunction

    function automatic logic [15:0] refImm();
        int v;
        v = int'(imm);
        if (imm_signed && v >= 128) v = v - 256 + 65536;
        return v[15:0];
    endfunction

    function automatic logic refReady();
        logic stall;
        stall = ex_wr_en && ex_is_load && ex_wr_addr != 3'd0 &&
                (ex_wr_addr == rs_addr || (!use_imm && ex_wr_addr == rt_addr));
        return !flush && !stall && (!mValid || out_ready);
    endfunction

    // Advance the model by one cycle from the current inputs, then cross the edge.
    task automatic tick();
        logic rdy;
        rdy = refReady();
        if (flush) begin
            mValid = 1'b0;
        end else if (in_valid && rdy) begin
            mValid = 1'b1;
            mA  = refSrc(rs_addr, rs_data);
            mB  = use_imm ? refImm() : refSrc(rt_addr, rt_data);
            mOp = alu_op_in;
            mRd = rd_addr;
        end else if (mValid && out_ready) begin
            mValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; rs_addr = 3'd0; rt_addr = 3'd0; rd_addr = 3'd0;
        rs_data = 16'h0; rt_data = 16'h0; imm = 8'h00; use_imm = 1'b0;
        imm_signed = 1'b0; alu_op_in = 3'd0; ex_wr_en = 1'b0; ex_wr_addr = 3'd0;
        ex_wr_data = 16'h0; ex_is_load = 1'b0; wb_wr_en = 1'b0; wb_wr_addr = 3'd0;
        wb_wr_data = 16'h0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        mValid = 1'b0; mA = 16'h0; mB = 16'h0; mOp = 3'd0; mRd = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, a, b, alu_op, rd_out} !== 39'd0) begin
            failures++;
            $display("FAIL reset_state got v=%0b a=%h b=%h op=%0d rd=%0d want all zero",
                     out_valid, a, b, alu_op, rd_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; rs_addr = 3'd1; rs_data = 16'h00F0; rt_addr = 3'd2;
        rt_data = 16'h0F0F; alu_op_in = 3'd4; rd_addr = 3'd5; out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, a, b, alu_op, rd_out} !== {1'b1, 16'h00F0, 16'h0F0F, 3'd4, 3'd5}) begin
            failures++;
            $display("FAIL basic_xor got v=%0b a=%h b=%h op=%0d rd=%0d want 1 00f0 0f0f 4 5",
                     out_valid, a, b, alu_op, rd_out);
        end
    endtask

    task automatic test_forward();
        rs_addr = 3'd3; rs_data = 16'hAAAA; ex_wr_en = 1'b1; ex_wr_addr = 3'd3;
        ex_wr_data = 16'h1234; wb_wr_en = 1'b1; wb_wr_addr = 3'd3; wb_wr_data = 16'h5555;
        tick();
        checks++;
        if (a !== 16'h1234) begin
            failures++;
            $display("FAIL fwd_ex_priority got a=%h want 1234", a);
        end
        ex_wr_en = 1'b0;
        tick();
        checks++;
        if (a !== 16'h5555) begin
            failures++;
            $display("FAIL fwd_wb got a=%h want 5555", a);
        end
        rs_addr = 3'd0; rs_data = 16'hABCD; ex_wr_en = 1'b1; ex_wr_addr = 3'd0;
        wb_wr_addr = 3'd0;
        tick();
        checks++;
        if (a !== 16'h0000) begin
            failures++;
            $display("FAIL fwd_r0 got a=%h want 0000", a);
        end
        idle();
    endtask

    task automatic test_imm();
        in_valid = 1'b1; rs_addr = 3'd1; rs_data = 16'h0011; rt_addr = 3'd6;
        use_imm = 1'b1; imm = 8'h80; imm_signed = 1'b1;
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 3'd6;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL imm_no_stall got in_ready=%0b want 1", in_ready);
        end
        tick();
        checks++;
        if (b !== 16'hFF80 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL imm_sign got b=%h v=%0b want ff80 1", b, out_valid);
        end
        imm_signed = 1'b0;
        tick();
        checks++;
        if (b !== 16'h0080) begin
            failures++;
            $display("FAIL imm_zero got b=%h want 0080", b);
        end
        idle();
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; rs_addr = 3'd4; rs_data = 16'h0000; rt_addr = 3'd2;
        rt_data = 16'h0002; rd_addr = 3'd7; alu_op_in = 3'd0;
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 3'd4;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_use_ready got %0b want 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_use_bubble got out_valid=%0b want 0", out_valid);
        end
        ex_wr_en = 1'b0; ex_is_load = 1'b0; wb_wr_en = 1'b1; wb_wr_addr = 3'd4;
        wb_wr_data = 16'hBEEF;
        tick();
        checks++;
        if (out_valid !== 1'b1 || a !== 16'hBEEF) begin
            failures++;
            $display("FAIL load_use_wb got v=%0b a=%h want 1 beef", out_valid, a);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; rs_addr = 3'd1; rs_data = 16'h1111; rt_addr = 3'd2;
        rt_data = 16'h2222; alu_op_in = 3'd1; rd_addr = 3'd3;
        tick();
        out_ready = 1'b0; rs_data = 16'h3333; rt_data = 16'h4444; alu_op_in = 3'd2;
        rd_addr = 3'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready cycle %0d got %0b want 0", i, in_ready);
            end
            tick();
            checks++;
            if ({out_valid, a, b, alu_op, rd_out} !== {1'b1, 16'h1111, 16'h2222, 3'd1, 3'd3}) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got v=%0b a=%h b=%h op=%0d rd=%0d want 1 1111 2222 1 3",
                         i, out_valid, a, b, alu_op, rd_out);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got %0b want 1", in_ready);
        end
        tick();
        checks++;
        if ({out_valid, a, b, alu_op, rd_out} !== {1'b1, 16'h3333, 16'h4444, 3'd2, 3'd6}) begin
            failures++;
            $display("FAIL bp_no_bubble got v=%0b a=%h b=%h op=%0d rd=%0d want 1 3333 4444 2 6",
                     out_valid, a, b, alu_op, rd_out);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; rs_data = 16'h7777; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got %0b want 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop got out_valid=%0b want 0", out_valid);
        end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_nocapture got out_valid=%0b want 0", out_valid);
        end
        idle();
    endtask

    task automatic test_random();
        logic held;
        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                rs_addr    = 3'($urandom_range(0, 7));
                rt_addr    = 3'($urandom_range(0, 7));
                rd_addr    = 3'($urandom_range(0, 7));
                rs_data    = 16'($urandom);
                rt_data    = 16'($urandom);
                imm        = 8'($urandom);
                use_imm    = 1'($urandom_range(0, 1));
                imm_signed = 1'($urandom_range(0, 1));
                alu_op_in  = 3'($urandom_range(0, 5));
            end
            ex_wr_en   = 1'($urandom_range(0, 1));
            ex_is_load = ($urandom_range(0, 3) == 0);
            ex_wr_addr = 3'($urandom_range(0, 7));
            ex_wr_data = 16'($urandom);
            wb_wr_en   = 1'($urandom_range(0, 1));
            wb_wr_addr = 3'($urandom_range(0, 7));
            wb_wr_data = 16'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (in_ready !== refReady()) begin
                failures++;
                $display("FAIL rand_ready cycle %0d got %0b want %0b", i, in_ready, refReady());
            end
            held = in_valid && !refReady() && !flush;
            tick();
            checks++;
            if (out_valid !== mValid ||
                (mValid && {a, b, alu_op, rd_out} !== {mA, mB, mOp, mRd})) begin
                failures++;
                $display("FAIL rand_out cycle %0d got v=%0b a=%h b=%h op=%0d rd=%0d want v=%0b a=%h b=%h op=%0d rd=%0d",
                         i, out_valid, a, b, alu_op, rd_out, mValid, mA, mB, mOp, mRd);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; rs_addr = 3'd5; rs_data = 16'h5A5A; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_setup got out_valid=%0b want 1", out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || a !== 16'h0000) begin
            failures++;
            $display("FAIL arst_immediate got v=%0b a=%h want 0 0000", out_valid, a);
        end
        mValid = 1'b0; mA = 16'h0; mB = 16'h0; mOp = 3'd0; mRd = 3'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_imm();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline register between decode/register-file read and the 16-bit ALU (add/sub/and/or/xor/slt datapaths).
- Selects each operand from the register file, the EX-stage result or the WB-stage result, applies the immediate path, and holds a registered {a, b, alu_op, rd} bundle for the ALU.
- Uses a valid/ready handshake on both sides, supports flush, and stalls on load-use hazards.

Parameters:
- DATA_W, 16, operand/result width.
- REG_AW, 3, register address width (8 registers; register 0 hard-wired zero).
- OP_W, 3, ALU operation code width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode bundle present.
- in_ready  output  1  stage accepts bundle this cycle.
- rs_addr  input  REG_AW  source-A register index.
- rt_addr  input  REG_AW  source-B register index.
- rd_addr  input  REG_AW  destination register index.
- rs_data  input  DATA_W  register-file read of rs.
- rt_data  input  DATA_W  register-file read of rt.
- imm  input  DATA_W/2+... (8)  raw immediate field.
- use_imm  input  1  operand B is the extended immediate.
- imm_signed  input  1  1 = sign-extend imm, 0 = zero-extend.
- alu_op_in  input  OP_W  ALU operation.
- ex_wr_en  input  1  EX stage will write a register.
- ex_wr_addr  input  REG_AW  EX destination.
- ex_wr_data  input  DATA_W  EX result.
- ex_is_load  input  1  EX instruction is a load; data not yet valid.
- wb_wr_en  input  1  WB stage writes a register.
- wb_wr_addr  input  REG_AW  WB destination.
- wb_wr_data  input  DATA_W  WB result.
- flush  input  1  discard held bundle and current input.
- out_valid  output  1  registered bundle valid.
- out_ready  input  1  ALU stage consumes bundle.
- a  output  DATA_W  registered operand A.
- b  output  DATA_W  registered operand B.
- alu_op  output  OP_W  registered operation.
- rd_out  output  REG_AW  registered destination.

Behaviour:
- Reset (async, immediate): out_valid=0, a=0, b=0, alu_op=0, rd_out=0. in_ready follows its equation (1 after reset when no hazard).
- Immediate extension: 8-bit imm to DATA_W; sign-extend when imm_signed=1, zero-extend otherwise.
- Forwarding per source (rs, rt) is combinational on the input side:
  - Address 0 always yields 0, with no forwarding.
  - Else if ex_wr_en, address match and !ex_is_load: use ex_wr_data.
  - Else if wb_wr_en and address match: use wb_wr_data.
  - Else use the register-file data.
  - EX has priority over WB.
- B = use_imm ? extended imm : forwarded rt. When use_imm=1, rt is not a hazard source.
- Load-use hazard: ex_wr_en & ex_is_load & ex_wr_addr!=0 & ex_wr_addr matches rs, or rt when !use_imm.
- in_ready = !hazard & (!out_valid | out_ready).
- Transfer occurs when in_valid & in_ready. The bundle is registered at the next edge; latency is 1 cycle.
- Registered state:
  - If out_valid & !out_ready, hold all outputs unchanged (back-pressure).
  - A consume (out_valid & out_ready) with no transfer sets out_valid=0. Data regs keep their value.
  - Simultaneous consume and transfer: load the new bundle and keep out_valid=1. No bubble.
  - Hazard with in_valid=1: no transfer; out_valid clears once the old bundle is consumed, inserting a bubble.
- flush (synchronous, highest priority after reset):
  - Next edge out_valid=0 and the input is not captured; in_ready is forced 0 during flush.
  - Data regs may retain their value.
- Handshake rules:
  - Once out_valid=1, a/b/alu_op/rd_out must stay stable until consumed.
  - Upstream must hold its inputs stable while in_valid & !in_ready.
- Reset asserted mid-operation drops any held bundle; there is no partial-state recovery.

Test Plan:
- Reset, then in_valid with rs=1 (rs_data=0x00F0), rt=2 (rt_data=0x0F0F), alu_op=xor, out_ready=1 -> next cycle out_valid=1, a=0x00F0, b=0x0F0F, rd_out as given.
- rs=3 with ex_wr_en, ex_wr_addr=3, ex_wr_data=0x1234, and wb also writing 3 with 0x5555 -> a=0x1234 (EX priority). Repeat with rs=0 and ex_wr_addr=0 -> a=0x0000.
- use_imm=1, imm=0x80: imm_signed=1 -> b=0xFF80; imm_signed=0 -> b=0x0080. An rt match against an EX load must not stall.
- ex_is_load=1, ex_wr_addr=rs=4 -> in_ready=0 and one bubble (out_valid=0). Next cycle with the load in WB (wb_wr_data=0xBEEF) -> a=0xBEEF.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0. Then out_ready=1 with in_valid=1 -> the new bundle appears the next cycle with no bubble.
- flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, nothing captured. Reset asserted mid-stream -> out_valid drops immediately (async).
